// File: rtl/i2c_slave_endpoint.sv
// ---------------------------------------------------------------------------
// i2c_slave_endpoint
//
// Single-address I2C slave. SCL and SDA are oversampled on clk through short
// synchronizer chains; START / repeated START / STOP are detected from the
// synchronized lines. A matching 7-bit address is ACKed. Write bytes are
// presented on rx_data with a one-cycle rx_valid pulse. Read bytes are taken
// from tx_data (captured on each tx_load pulse) and shifted out MSB first.
//
// Ports:
//   clk        system clock, at least 8x the SCL frequency
//   reset_n    asynchronous active-low reset (release synchronous to clk)
//   SCL        bus clock from the master
//   SDA        open-drain bus data; pulled low only while sda_oe is high
//   tx_data    byte returned on reads, captured when tx_load pulses
//   rx_data    last byte received in a write
//   rx_valid   one-cycle pulse, new byte on rx_data
//   tx_load    one-cycle pulse, tx_data copied into the shift register
//   addressed  high from the address ACK until STOP, START or master NACK
//   bus_busy   high between START and STOP
//   sda_oe     SDA pull-down enable (also exported for debug)
// ---------------------------------------------------------------------------
module i2c_slave_endpoint #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       addressed,
    output logic       bus_busy,
    output logic       sda_oe
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. Idle bus level is high, so the chains reset to 1
    // to avoid a spurious edge right after reset.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    scl_sync_reg[gi] <= 1'b1;
                    sda_sync_reg[gi] <= 1'b1;
                end else if (gi == 0) begin
                    scl_sync_reg[gi] <= SCL;
                    sda_sync_reg[gi] <= SDA;
                end else begin
                    scl_sync_reg[gi] <= scl_sync_reg[(gi > 0) ? gi - 1 : 0];
                    sda_sync_reg[gi] <= sda_sync_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_prev_reg <= scl_sync_reg[SYNC_STAGES-1];
            sda_prev_reg <= sda_sync_reg[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_prev_reg;
    assign scl_fall  = ~scl_s &  scl_prev_reg;
    // SCL must be high on both samples so an SDA change right at an SCL
    // edge is never mistaken for a bus condition.
    assign start_det = scl_s & scl_prev_reg &  sda_prev_reg & ~sda_s;
    assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg &  sda_s;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t     state_reg,     state_next;
    logic [2:0] bit_cnt_reg,   bit_cnt_next;
    logic [7:0] shift_reg,     shift_next;
    logic       rw_reg,        rw_next;
    // In the ACK states: set once the ACK pull-down has started (slave ACK)
    // or the master's ACK has been sampled (RD_ACK).
    logic       ack_on_reg,    ack_on_next;
    logic       sda_oe_reg,    sda_oe_next;
    logic       addressed_reg, addressed_next;
    logic       bus_busy_reg,  bus_busy_next;
    logic [7:0] rx_data_reg,   rx_data_next;
    logic       rx_valid_reg,  rx_valid_next;
    logic       tx_load_reg,   tx_load_next;

    logic       bit_last;      // terminal flag: current bit is the 8th
    logic [7:0] byte_in;

    assign bit_last = (bit_cnt_reg == 3'd7);
    assign byte_in  = {shift_reg[6:0], sda_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            rw_reg        <= 1'b0;
            ack_on_reg    <= 1'b0;
            sda_oe_reg    <= 1'b0;
            addressed_reg <= 1'b0;
            bus_busy_reg  <= 1'b0;
            rx_data_reg   <= 8'd0;
            rx_valid_reg  <= 1'b0;
            tx_load_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            rw_reg        <= rw_next;
            ack_on_reg    <= ack_on_next;
            sda_oe_reg    <= sda_oe_next;
            addressed_reg <= addressed_next;
            bus_busy_reg  <= bus_busy_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            tx_load_reg   <= tx_load_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        rw_next        = rw_reg;
        ack_on_next    = ack_on_reg;
        sda_oe_next    = sda_oe_reg;
        addressed_next = addressed_reg;
        bus_busy_next  = bus_busy_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = 1'b0;
        tx_load_next   = 1'b0;

        if (start_det) begin
            // START or repeated START, accepted from any state.
            state_next     = ADDR;
            bit_cnt_next   = 3'd0;
            ack_on_next    = 1'b0;
            sda_oe_next    = 1'b0;
            addressed_next = 1'b0;
            bus_busy_next  = 1'b1;
        end else if (stop_det) begin
            state_next     = IDLE;
            ack_on_next    = 1'b0;
            sda_oe_next    = 1'b0;
            addressed_next = 1'b0;
            bus_busy_next  = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    // Without a START every SCL edge is ignored.
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_next = byte_in;
                        if (bit_last) begin
                            bit_cnt_next = 3'd0;
                            rw_next      = sda_s;
                            ack_on_next  = 1'b0;
                            state_next   = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                        end
                    end
                end

                ADDR_ACK, WR_ACK: begin
                    // First fall (end of 8th clock) starts the ACK pull-down,
                    // second fall (end of 9th clock) ends it.
                    if (scl_fall) begin
                        if (!ack_on_reg) begin
                            ack_on_next = 1'b1;
                            sda_oe_next = 1'b1;
                            if (state_reg == ADDR_ACK) begin
                                addressed_next = 1'b1;
                            end
                        end else begin
                            ack_on_next  = 1'b0;
                            bit_cnt_next = 3'd0;
                            if (state_reg == ADDR_ACK && rw_reg) begin
                                // Read: the first data bit goes out on the
                                // same fall that ends the ACK.
                                state_next   = RD_DATA;
                                tx_load_next = 1'b1;
                                shift_next   = tx_data;
                                sda_oe_next  = ~tx_data[7];
                            end else begin
                                state_next  = WR_DATA;
                                sda_oe_next = 1'b0;
                            end
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise) begin
                        shift_next = byte_in;
                        if (bit_last) begin
                            bit_cnt_next  = 3'd0;
                            rx_data_next  = byte_in;
                            rx_valid_next = 1'b1;
                            ack_on_next   = 1'b0;
                            state_next    = WR_ACK;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                        end
                    end
                end

                RD_DATA: begin
                    // bit_cnt counts the bits already presented beyond the MSB.
                    if (scl_fall) begin
                        if (bit_last) begin
                            bit_cnt_next = 3'd0;
                            sda_oe_next  = 1'b0;
                            ack_on_next  = 1'b0;
                            state_next   = RD_ACK;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                            shift_next   = {shift_reg[6:0], 1'b0};
                            sda_oe_next  = ~shift_reg[6];
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ack_on_next = 1'b1;
                        end else begin
                            // Master NACK ends the read.
                            state_next     = IGNORE;
                            sda_oe_next    = 1'b0;
                            addressed_next = 1'b0;
                        end
                    end else if (scl_fall && ack_on_reg) begin
                        ack_on_next  = 1'b0;
                        bit_cnt_next = 3'd0;
                        tx_load_next = 1'b1;
                        shift_next   = tx_data;
                        sda_oe_next  = ~tx_data[7];
                        state_next   = RD_DATA;
                    end
                end

                IGNORE: begin
                    sda_oe_next = 1'b0;
                end

                default: begin
                    state_next  = IDLE;
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    // Open-drain pad: only ever pull low.
    assign SDA = sda_oe_reg ? 1'b0 : 1'bz;

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign tx_load   = tx_load_reg;
    assign addressed = addressed_reg;
    assign bus_busy  = bus_busy_reg;
    assign sda_oe    = sda_oe_reg;

endmodule

// File: doc/i2c_slave_endpoint.md
Name: i2c_slave_endpoint

Overview:
- Downstream consumer of the I2C master: a single-address I2C slave attached to the master's SCL/SDA bus lines.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs, receives write bytes into a data port and shifts out read bytes from a data port.
- Serves as the bus-side endpoint for system integration and as the master's verification counterpart.

Parameters:
- SLAVE_ADDR, 7'h2A, 7-bit bus address this endpoint responds to.
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronizers (min 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- reset_n  input  1  asynchronous, active-low reset; deassertion synchronous to clk.
- SCL  input  1  bus clock from master.
- SDA  inout  1  bus data, open-drain: driven 1'b0 when sda_oe=1, else 1'bz.
- tx_data  input  8  byte to return on reads; sampled when tx_load pulses.
- rx_data  output  8  last received write byte.
- rx_valid  output  1  one-cycle pulse; new byte on rx_data.
- tx_load  output  1  one-cycle pulse; tx_data captured into the shift register.
- addressed  output  1  high from address-match ACK until STOP, START or NACK.
- bus_busy  output  1  high between START and STOP.
- sda_oe  output  1  SDA pull-down enable; exported for debug.

Behaviour:
- Reset: all outputs 0, state IDLE, shift register 0, bit count 0, SDA released.
- Synchronizers: SCL and SDA each pass through SYNC_STAGES flops. Edges are taken from the last stage vs. its previous value (scl_rise, scl_fall).
- START: synced SDA falls while synced SCL is high. Takes effect in any state (repeated START): go to ADDR, clear bit count, release SDA, drop addressed, set bus_busy.
- STOP: synced SDA rises while SCL is high. Go to IDLE, release SDA, clear bus_busy and addressed.
- START/STOP detection has priority over any data-bit event in the same cycle.
- Bit sampling: on scl_rise; MSB first.
- SDA changes only: at most one clk after scl_fall, never while SCL is high.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- ADDR:
  - Shift 8 bits.
  - At 8th scl_rise: if bits[7:1]==SLAVE_ADDR, go to ADDR_ACK; else go to IGNORE.
  - bit0 (R/W) is latched: 1 = read.
- ADDR_ACK:
  - At next scl_fall: sda_oe=1, addressed=1.
  - At following scl_fall (end of 9th clock): sda_oe=0.
  - Then go to WR_DATA if write.
  - If read: go to RD_DATA. On that same scl_fall, pulse tx_load, capture tx_data, and set sda_oe = ~tx_data[7].
- WR_DATA:
  - Shift 8 bits.
  - At 8th scl_rise: rx_data <= byte and rx_valid pulses for one clk. Go to WR_ACK.
  - Every byte is ACKed; no overflow condition.
- WR_ACK: same ACK timing as ADDR_ACK, then return to WR_DATA with bit count 0.
- RD_DATA:
  - On each scl_fall after a bit is presented, shift left and set sda_oe = ~next bit.
  - After the 8th bit's scl_fall: sda_oe=0, go to RD_ACK.
- RD_ACK:
  - Sample SDA at scl_rise.
  - 0 (master ACK): at next scl_fall, pulse tx_load, reload tx_data, drive its MSB, go to RD_DATA.
  - 1 (NACK): go to IGNORE with SDA released, addressed=0.
- IGNORE: SDA released; wait for START or STOP.
- Bit counter: 3 bits plus a terminal flag, reset by START and after each ACK phase.
- Reset mid-transfer: SDA released immediately (asynchronous), FSM to IDLE. The next START is required before any response.
- SCL edges while IDLE (no START seen): ignored.

Test Plan:
- Write addr 0x2A, data 0xA5 → ACK low on both 9th clocks; rx_data=0xA5; exactly one rx_valid pulse; addressed=1 until STOP, then bus_busy=0.
- Write to addr 0x15 → SDA never driven (sda_oe stays 0); master sees NACK; no rx_valid; state IGNORE until STOP.
- Read addr 0x2A, tx_data=0x3C, master NACKs → SDA bits 0,0,1,1,1,1,0,0; one tx_load; SDA released at 9th clock.
- Read two bytes with master ACK, tx_data changed 0x81→0x7E after first tx_load → bytes 0x81 then 0x7E; two tx_load pulses.
- Write 0x11, repeated START, then read → rx_data=0x11; FSM re-enters ADDR without STOP; read byte returned correctly.
- reset_n low during 5th data bit of a read → sda_oe=0 within the same clk; all outputs 0; next transaction after a new START behaves normally.
